// File: rtl/video_frame_capture_if.sv
// Pixel-stream and frame-buffer write bundle for video_frame_capture.
// slave  : the capture block (consumes the pixel stream, drives the write port).
// master : the environment (drives the pixel stream, observes the write port).
interface video_frame_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 20
);
  logic              pre_img_vsync;
  logic              pre_img_hsync;
  logic              pre_img_valid;
  logic [DATA_W-1:0] pre_img_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid, pre_img_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/video_frame_capture.sv
// video_frame_capture: stream sink that rebuilds pixel coordinates, writes
// each active pixel to a linear frame buffer at row*H_DISP+col, pulses
// frame_done on completion and keeps sticky geometry error flags
// ([0] short line, [1] long line, [2] short frame).
// Optional feature: define FRAME_CAPTURE_CHECKSUM_EN to add the frame_sum
// output (32-bit wrapping sum of all pixels written in a completed frame).
module video_frame_capture #(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture_en,
  input  logic                 err_clr,
  video_frame_capture_if.slave vif,
  output logic                 frame_done,
  output logic                 busy,
  output logic [2:0]           err_flags
`ifdef FRAME_CAPTURE_CHECKSUM_EN
  ,
  output logic [31:0]          frame_sum
`endif
);

  localparam int COL_W = $clog2(H_DISP + 1);
  localparam int ROW_W = $clog2(V_DISP + 1);
  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(H_DISP);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_DISP - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(V_DISP);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_DISP - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_DISP);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t            state;
  logic              vsync_r;
  logic              valid_r;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr_ptr;   // address of the next pixel in the current line
  logic [ADDR_W-1:0] row_base;   // row*H_DISP, advanced by H_DISP per line
  logic              long_seen;  // long-line error already raised on this line
  logic              done_pend;  // last pixel of the frame was written last edge

  logic       vs_rise;
  logic       line_end;
  logic       capturing;
  logic       in_line;
  logic       pix_ok;
  logic       last_pix;
  logic       start_frame;
  logic [2:0] err_set;

  // hsync carries no information the coordinate rebuild needs.
  logic hsync_unused;
  assign hsync_unused = vif.pre_img_hsync;

  assign busy = (state == CAPTURE);

  // Event decode and per-cycle write/error decisions.
  always_comb begin
    vs_rise     = vif.pre_img_vsync & ~vsync_r;
    line_end    = ~vif.pre_img_valid & valid_r;
    capturing   = (state == CAPTURE) && !done_pend;
    // The vsync-rise cycle only (re)starts a frame; its pixel is not taken.
    in_line     = capturing && !vs_rise;
    pix_ok      = in_line && vif.pre_img_valid && (col < COL_MAX) && (row < ROW_MAX);
    last_pix    = pix_ok && (col == COL_LAST) && (row == ROW_LAST);
    start_frame = ((state == WAIT_VS) && capture_en && vs_rise) || (capturing && vs_rise);
    err_set     = '0;
    // col != 0 ignores a falling valid that belongs to pixels seen before capture started.
    err_set[0]  = in_line && line_end && (col != '0) && (col < COL_MAX) && (row < ROW_MAX);
    err_set[1]  = in_line && vif.pre_img_valid && (col == COL_MAX) && !long_seen && (row < ROW_MAX);
    err_set[2]  = capturing && vs_rise;
  end

  // Control FSM, coordinate tracking, write port and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_r     <= 1'b0;
      valid_r     <= 1'b0;
      col         <= '0;
      row         <= '0;
      addr_ptr    <= '0;
      row_base    <= '0;
      long_seen   <= 1'b0;
      done_pend   <= 1'b0;
      vif.wr_en   <= 1'b0;
      vif.wr_addr <= '0;
      vif.wr_data <= '0;
      frame_done  <= 1'b0;
      err_flags   <= '0;
    end else begin
      vsync_r    <= vif.pre_img_vsync;
      valid_r    <= vif.pre_img_valid;
      vif.wr_en  <= pix_ok;
      if (pix_ok) begin
        vif.wr_addr <= addr_ptr;
        vif.wr_data <= vif.pre_img_data;
      end
      frame_done <= 1'b0;
      done_pend  <= last_pix;
      // A new error event in the same cycle as err_clr keeps its bit set.
      err_flags  <= (err_clr ? 3'b000 : err_flags) | err_set;

      if (start_frame) begin
        col       <= '0;
        row       <= '0;
        addr_ptr  <= '0;
        row_base  <= '0;
        long_seen <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (capture_en) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!capture_en)  state <= IDLE;
          else if (vs_rise) state <= CAPTURE;
        end
        CAPTURE: begin
          if (done_pend) begin
            frame_done <= 1'b1;
            state      <= capture_en ? WAIT_VS : IDLE;
          end else if (!vs_rise) begin
            if (vif.pre_img_valid) begin
              if (col != COL_MAX) col <= col + 1'b1;
              if (pix_ok)         addr_ptr <= addr_ptr + 1'b1;
              if (err_set[1])     long_seen <= 1'b1;
            end else if (line_end && (col != '0)) begin
              col       <= '0;
              long_seen <= 1'b0;
              if (row != ROW_MAX) begin
                row      <= row + 1'b1;
                row_base <= row_base + LINE_STEP;
                addr_ptr <= row_base + LINE_STEP;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
  logic [31:0] sum_acc;

  // Running pixel sum of the frame in progress; published only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc   <= '0;
      frame_sum <= '0;
    end else begin
      if (start_frame)  sum_acc <= '0;
      else if (pix_ok)  sum_acc <= sum_acc + 32'(vif.pre_img_data);
      if ((state == CAPTURE) && done_pend) frame_sum <= sum_acc;
    end
  end
`endif

endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Stream sink for the pixel stream produced by the image pipeline (vsync/hsync/valid/data, 1280x720 active window).
- Rebuilds pixel coordinates, writes each active pixel to a linear frame-buffer write port at address row*H_DISP+col, and signals frame completion.
- Checks line and frame geometry and reports violations as sticky flags.
- Synthesizable counterpart of the bench-side frame dump; sits between processing cores and the frame buffer/DDR writer.

Parameters:
- H_DISP, 1280, active pixels per line.
- V_DISP, 720, active lines per frame.
- DATA_W, 8, pixel width.
- ADDR_W, 20, frame-buffer address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- capture_en  in  1  level; arms capture of successive frames.
- err_clr  in  1  one-cycle pulse; clears err_flags.
- pre_img_vsync  in  1  frame sync, active high.
- pre_img_hsync  in  1  line sync, active high; informational only.
- pre_img_valid  in  1  active pixel qualifier.
- pre_img_data  in  DATA_W  pixel.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- frame_done  out  1  one-cycle pulse; frame complete.
- busy  out  1  high in CAPTURE state.
- err_flags  out  3  sticky: [0] short line, [1] long line, [2] short frame.

Behaviour:
- Reset value of all outputs is 0. Reset values of internal state: FSM=IDLE, col=0, row=0, vsync_r=0, valid_r=0.
- Inputs are sampled on posedge clk.
- vs_rise is vsync & ~vsync_r.
- line_end is ~valid & valid_r.
- FSM:
  - IDLE: go to WAIT_VS when capture_en=1.
  - WAIT_VS: go to IDLE if capture_en=0. Go to CAPTURE on vs_rise; clear col and row.
  - CAPTURE: capture pixels. On completion go to WAIT_VS if capture_en=1, else IDLE.
  - capture_en deasserted in CAPTURE does not abort; the current frame finishes first.
- Write path in CAPTURE:
  - For each valid pixel with col<H_DISP and row<V_DISP: wr_en=1, wr_addr=row*H_DISP+col, wr_data=data. All three are registered, so latency is exactly 1 cycle from the sampled pixel.
  - Address uses an incrementing pointer, not a multiplier.
  - col increments on every valid pixel, saturating at H_DISP.
- Pixels with col>=H_DISP are dropped and set err[1], once per line.
- On line_end:
  - If col<H_DISP, set err[0]. The line still counts.
  - row increments and col clears.
- Pixels with row>=V_DISP are dropped.
- Completion: the write of pixel (V_DISP-1, H_DISP-1) is the last write. frame_done pulses in the cycle after wr_en of that write, i.e. 2 cycles after the pixel is sampled. The FSM leaves CAPTURE on the same edge.
- vs_rise in CAPTURE before completion:
  - Set err[2]; no frame_done.
  - Restart capture of the new frame in place: col=0, row=0, stay in CAPTURE.
- valid in WAIT_VS or IDLE is ignored (no writes).
- err_clr clears err_flags. A new error event in the same cycle wins, so that bit is set.
- busy equals (state==CAPTURE).
- Reset asserted mid-frame: outputs clear immediately (asynchronous). After release, the block waits for the next vs_rise and never resumes the partial frame.

Optional Feature:
- Macro FRAME_CAPTURE_CHECKSUM_EN.
- When defined:
  - Adds output frame_sum [31:0].
  - A 32-bit wrapping sum of every written wr_data, cleared at capture start.
  - frame_sum is registered and updated in the same cycle frame_done pulses; it holds until the next completed frame.
  - Not updated on an aborted frame.
- When undefined: port absent, no accumulator logic.

Test Plan:
1. H_DISP=8, V_DISP=4, capture_en=1; one frame with data=row*8+col and gaps between lines -> 32 writes at addr 0..31 with wr_data==addr, each 1 cycle after its valid; frame_done one pulse 1 cycle after the addr-31 write; err_flags=0; FSM back in WAIT_VS.
2. Same setup, line 2 carries 6 pixels -> err_flags=3'b001. Line 3 writes addr 24..31. Total of 30 writes, since the last write is at addr 31 no frame_done... instead frame_done fires only after a pixel at (3,7) is written: it is, so frame_done=1.
3. Line 1 carries 10 pixels -> writes addr 8..15 only; err_flags=3'b010; pixels 9 and 10 are not written.
4. vs_rise after 2 lines (16 writes), then a full frame -> err_flags[2]=1; no frame_done for the first frame; second frame writes addr 0..31 and frame_done pulses once; pulse err_clr -> err_flags=0.
5. Deassert capture_en after row 1 of a frame -> frame completes with frame_done, then FSM goes to IDLE and busy=0; a following frame produces no writes.
6. Assert rst_n=0 mid-line -> wr_en, busy, err_flags =0 asynchronously. Release and send valid pixels before vsync -> no writes. Send a full frame with FRAME_CAPTURE_CHECKSUM_EN -> frame_sum=496 (sum 0..31) with frame_done.
